restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result bit width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin a division, sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH, the dividend.
REQ-006 The block SHALL have port B, input, WIDTH, the divisor.
REQ-007 The block SHALL have port busy, output, 1, high in CALC and DONE.
REQ-008 The block SHALL have port done, output, 1, a registered one-cycle completion pulse.
REQ-009 The block SHALL have port Q, output, WIDTH, the quotient.
REQ-010 The block SHALL have port R, output, WIDTH, the remainder.
REQ-011 The block SHALL have port divByZero, output, 1, high when the last completed operation had B==0.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE; reset state IDLE.
REQ-013 In IDLE with start=1, the block SHALL latch A and B into internal registers, clear the partial remainder, load the iteration counter with WIDTH, and go to CALC (B!=0) or DONE (B==0).
REQ-014 In CALC, each cycle SHALL shift {remainder,dividend} left 1 and trial-subtract the divisor at WIDTH+1 bits; if non-negative, keep the difference and set the quotient LSB to 1, else restore and set it to 0.
REQ-015 After exactly WIDTH CALC cycles the FSM SHALL go to DONE; Q, R and divByZero SHALL update on that same edge.
REQ-016 The DONE state SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency SHALL be done high WIDTH+1 edges after the accepting edge (17 for WIDTH=16), and 1 edge after it for B==0.
REQ-018 For B==0, Q SHALL be all ones, R SHALL equal A, and divByZero SHALL be 1; otherwise divByZero SHALL be 0.
REQ-019 The block SHALL ignore start while busy=1; latched operands SHALL not change mid-operation, and A/B changes after acceptance SHALL have no effect.
REQ-020 Q, R and divByZero SHALL hold their values until the next completion.
REQ-021 start held high continuously SHALL cause back-to-back operations, each accepted in the IDLE cycle following DONE.

Reset
REQ-022 Reset SHALL force state IDLE, busy=0, done=0, Q=0, R=0, divByZero=0, and clear internal registers.
REQ-023 Reset during CALC or DONE SHALL abort the operation with no done pulse; reset has priority over start.

Configuration
REQ-024 Macro RESTORING_DIVIDER_SIGNED_EN: when defined, A, B, Q and R SHALL be two's complement; magnitudes are divided; Q is negated if sign(A)!=sign(B); R takes the sign of A.
REQ-025 With the macro defined, sign fix-up SHALL occur on the DONE-entry edge without adding latency; the most negative value / -1 SHALL yield Q=most negative value and R=0 (wrap); B==0 behaviour is unchanged (Q all ones, R=A).
REQ-026 With the macro undefined, all operands and results SHALL be unsigned.

Structure
REQ-027 State encodings (IDLE=0, CALC=1, DONE=2) and the default WIDTH SHALL live in the shared package calc_pkg.
REQ-028 The WIDTH+1-bit trial subtract (difference plus borrow) SHALL be sub-module divider_sub_stage; all other logic SHALL be in restoring_divider.

Verification
REQ-029 A=100, B=7, start pulse -> done 17 edges later, Q=14, R=2, divByZero=0.
REQ-030 A=0xFFFF, B=0x0001 -> Q=0xFFFF, R=0; A=0x0003, B=0x0010 -> Q=0, R=3.
REQ-031 A=0x1234, B=0 -> done 1 edge after acceptance, Q=0xFFFF, R=0x1234, divByZero=1.
REQ-032 After 100/7 is accepted, drive start with A=50, B=5 at cycle 5 -> ignored; result is Q=14, R=2.
REQ-033 Assert reset at CALC cycle 8 -> next edge busy=0, Q=R=0, and no done pulse.
REQ-034 With RESTORING_DIVIDER_SIGNED_EN: A=-100 (0xFF9C), B=7 -> Q=0xFFF2 (-14), R=0xFFFE (-2); A=0x8000, B=0xFFFF -> Q=0x8000, R=0.

Source files
------------

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared constants for the restoring divider:
//   DEFAULT_WIDTH  - default operand/result width
//   IDLE/CALC/DONE - FSM state encodings, kept as plain constants so older
//                    blocks that compare against raw state values still work
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/divider_sub_stage.sv
// -----------------------------------------------------------------------------
// divider_sub_stage
// One WIDTH+1-bit trial subtraction of the restoring divider.
//   minuend [WIDTH:0]   - shifted partial remainder
//   divisor [WIDTH-1:0] - divisor magnitude
//   diff    [WIDTH-1:0] - minuend - divisor (valid when borrow is 0)
//   borrow              - 1 when minuend < divisor (result negative)
// -----------------------------------------------------------------------------
module divider_sub_stage
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so the shifted
  // minuend is below 2*divisor: a non-negative result fits in WIDTH bits
  // and a negative one always sets the top bit. The top bit is the borrow.
  assign trial  = minuend - {1'b0, divisor};
  assign diff   = trial[WIDTH-1:0];
  assign borrow = trial[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
// Multi-cycle restoring divider, one quotient bit per clock.
//   clk       - clock, rising edge
//   reset     - synchronous, active-high
//   start     - begin a division (only looked at while idle)
//   A, B      - dividend, divisor
//   busy      - high while calculating and during the completion cycle
//   done      - one-cycle completion pulse
//   Q, R      - quotient, remainder (held until the next completion)
//   divByZero - last completed operation had B == 0
// Build option: define RESTORING_DIVIDER_SIGNED_EN for two's-complement
// operands/results (magnitudes divided, signs fixed on completion).
// -----------------------------------------------------------------------------
module restoring_divider
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             divByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] dividendReg;  // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] divisorReg;
  logic [WIDTH-1:0] remReg;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trialDiff;
  logic             trialBorrow;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuot;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [WIDTH-1:0] qFinal;
  logic [WIDTH-1:0] rFinal;
  logic             lastIter;

  // Shift {remainder, dividend} left by one: the dividend MSB enters the remainder.
  assign shifted = {remReg, dividendReg[WIDTH-1]};

  divider_sub_stage #(.WIDTH(WIDTH)) subStage (
    .minuend (shifted),
    .divisor (divisorReg),
    .diff    (trialDiff),
    .borrow  (trialBorrow)
  );

  // Restore on borrow; quotient bit is the inverse of the borrow.
  assign nextRem  = trialBorrow ? shifted[WIDTH-1:0] : trialDiff;
  assign nextQuot = {dividendReg[WIDTH-2:0], ~trialBorrow};
  assign lastIter = (count == CNT_W'(1));

`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic qNeg;
  logic rNeg;

  // The most negative value negates to itself, which is its correct
  // unsigned magnitude, so no special case is needed on the way in.
  assign aMag   = A[WIDTH-1] ? -A : A;
  assign bMag   = B[WIDTH-1] ? -B : B;
  // Negating a quotient magnitude of 2^(WIDTH-1) wraps back to the most
  // negative value, giving the required most-negative / -1 result.
  assign qFinal = qNeg ? -nextQuot : nextQuot;
  assign rFinal = rNeg ? -nextRem : nextRem;
`else
  assign aMag   = A;
  assign bMag   = B;
  assign qFinal = nextQuot;
  assign rFinal = nextRem;
`endif

  assign busy = (state == CALC) || (state == DONE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dividendReg <= '0;
      divisorReg  <= '0;
      remReg      <= '0;
      count       <= '0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      divByZero   <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      qNeg        <= 1'b0;
      rNeg        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dividendReg <= aMag;
            divisorReg  <= bMag;
            remReg      <= '0;
            count       <= CNT_W'(WIDTH);
`ifdef RESTORING_DIVIDER_SIGNED_EN
            qNeg        <= A[WIDTH-1] ^ B[WIDTH-1];
            rNeg        <= A[WIDTH-1];
`endif
            if (B == '0) begin
              // Divide by zero completes immediately with a fixed result.
              state     <= DONE;
              done      <= 1'b1;
              Q         <= '1;
              R         <= A;
              divByZero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          dividendReg <= nextQuot;
          remReg      <= nextRem;
          count       <= count - 1'b1;
          if (lastIter) begin
            state     <= DONE;
            done      <= 1'b1;
            Q         <= qFinal;
            R         <= rFinal;
            divByZero <= 1'b0;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider
// Directed bench for restoring_divider (WIDTH=16). A behavioural model
// computes quotient/remainder with plain arithmetic and tracks when the
// result is due; a negedge process compares every output against it each
// cycle. Directed operations additionally check hand-computed literals.
// Latency is counted with the accepting edge as edge 1.
// -----------------------------------------------------------------------------
module tb_restoring_divider;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } resT;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             divByZero;

  int total = 0;
  int bad   = 0;
  logic checkEn = 1'b0;

  restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Q         (Q),
    .R         (R),
    .divByZero (divByZero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  // Reference division straight from the arithmetic definition.
  function automatic resT refDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    resT res;
    if (b == '0) begin
      res.q   = '1;
      res.r   = a;
      res.dbz = 1'b1;
    end else begin
`ifdef RESTORING_DIVIDER_SIGNED_EN
      int sa;
      int sb;
      sa    = int'($signed(a));
      sb    = int'($signed(b));
      res.q = WIDTH'(sa / sb);
      res.r = WIDTH'(sa % sb);
`else
      longint ua;
      longint ub;
      ua    = longint'(a);
      ub    = longint'(b);
      res.q = WIDTH'(ua / ub);
      res.r = WIDTH'(ua % ub);
`endif
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  // Model: accepted request -> result published WIDTH edges later
  // (immediately for B==0), one completion cycle, then idle again.
  logic mBusy;
  logic mDone;
  int   mLeft;
  resT  mRes;
  resT  pend;

  always @(posedge clk) begin
    if (reset) begin
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mLeft <= 0;
      mRes  <= '0;
    end else if (mDone) begin
      mDone <= 1'b0;
      mBusy <= 1'b0;
    end else if (mBusy) begin
      if (mLeft == 1) begin
        mDone <= 1'b1;
        mRes  <= pend;
      end
      mLeft <= mLeft - 1;
    end else if (start) begin
      mBusy <= 1'b1;
      pend  <= refDiv(A, B);
      if (B == '0) begin
        mDone <= 1'b1;
        mRes  <= refDiv(A, B);
      end else begin
        mLeft <= WIDTH;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      check("cmp_busy", busy, mBusy);
      check("cmp_done", done, mDone);
      check("cmp_q", Q, mRes.q);
      check("cmp_r", R, mRes.r);
      check("cmp_dbz", divByZero, mRes.dbz);
    end
  end

  // One operation with literal expectations. ignoreAt>0 injects a competing
  // start (50/5) at that edge count, which must have no effect.
  task automatic doOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] expQ, input logic [WIDTH-1:0] expR,
                      input logic expDbz, input int expEdges, input int ignoreAt);
    int edges;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    A = 16'hDEAD;  // operand changes after acceptance must not matter
    B = '0;
    while (!done && edges < 100) begin
      if (ignoreAt != 0 && edges == ignoreAt) begin
        A = 16'd50;
        B = 16'd5;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_latency"}, edges, expEdges);
    check({tag, "_q"}, Q, expQ);
    check({tag, "_r"}, R, expR);
    check({tag, "_dbz"}, divByZero, expDbz);
  endtask

  // Operation checked only by the model.
  task automatic runOnly(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int edges;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("model_op_completes", done, 1'b1);
  endtask

  logic [WIDTH-1:0] vecA [6] = '{16'hABCD, 16'h8000, 16'd5,  16'd7,    16'hFFFE, 16'd0};
  logic [WIDTH-1:0] vecB [6] = '{16'h0123, 16'd3,    16'd5,  16'hFFFF, 16'h00FF, 16'd9};

  initial begin
    int edges;
    int first;
    int second;
    logic doneSeen;

    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEn = 1'b1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_q", Q, 16'h0000);
    check("reset_r", R, 16'h0000);
    check("reset_dbz", divByZero, 1'b0);
    reset = 1'b0;

    doOp("div_100_7",    16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17, 0);
    doOp("div_ffff_1",   16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17, 0);
    doOp("div_3_16",     16'h0003, 16'h0010, 16'h0000, 16'h0003, 1'b0, 17, 0);
    doOp("div_by_zero",  16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1,  0);
    doOp("ignore_start", 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17, 5);

    repeat (4) @(negedge clk);
    check("hold_q", Q, 16'd14);
    check("hold_r", R, 16'd2);

`ifdef RESTORING_DIVIDER_SIGNED_EN
    doOp("neg100_7",   16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 17, 0);
    doOp("minneg_m1",  16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17, 0);
`else
    doOp("u_ff9c_7",   16'hFF9C, 16'd7,    16'd9348, 16'd0,    1'b0, 17, 0);
    doOp("u_8000_ffff",16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17, 0);
`endif

    for (int i = 0; i < 6; i++) runOnly(vecA[i], vecB[i]);

    // start held high: second acceptance in the idle cycle after completion.
    @(negedge clk);
    A = 16'd200;
    B = 16'd9;
    start = 1'b1;
    edges = 0;
    first = 0;
    second = 0;
    while (second == 0 && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) begin
        if (first == 0) first = edges;
        else second = edges;
      end
    end
    start = 1'b0;
    check("b2b_first", first, 17);
    check("b2b_second", second, 35);
    check("b2b_q", Q, 16'd22);
    check("b2b_r", R, 16'd2);

    // Reset in the middle of a calculation aborts it, even with start high.
    repeat (2) @(negedge clk);
    A = 16'd100;
    B = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_in_calc", busy, 1'b1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_q", Q, 16'h0000);
    check("abort_r", R, 16'h0000);
    reset = 1'b0;
    start = 1'b0;
    doneSeen = 1'b0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (done) doneSeen = 1'b1;
    end
    check("abort_no_done", doneSeen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
